// File: rtl/capture_block.sv
// capture_block: selects one 8-bit source, decimates it, waits for a trigger, packs 4 samples per 32-bit word.
// Latency: a word's valid rises 2 clk after its 4th kept input sample is presented (source register, then pack/load).
// Backpressure: one-word output register; a word completing while valid&&!ready is dropped and sets sticky overflow.
//
// Optional feature macro: CAPTURE_HEADER_EN -- on trigger, emit a header word {8'hA5, pre_cnt[23:0]} first,
// where pre_cnt counts kept samples seen in ARMED before the trigger (saturating).
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-low reset
//   i_arm, i_abort      start-capture pulse (IDLE only, length!=0); cancel (wins over arm)
//   i_src_sel           0 ina, 1 inb, 2 ddsa, 3 ddsb, 4 aud[15:8], 5 mpx[15:8], 6-7 zero
//   i_*_data/_in        signed sample sources
//   i_decim             keep 1 of every decim+1 samples
//   i_trig_mode         0/3 immediate, 1 rising, 2 falling; i_trig_level signed threshold
//   i_length            capture length in words (latched on arm)
//   o_usb_wr_*          valid/ready word stream, first sample in [7:0]
//   o_busy, o_done, o_overflow  status: not idle, completion pulse, sticky dropped-word flag
module capture_block #(
  parameter int DECIM_WIDTH = 16,
  parameter int LEN_WIDTH   = 24
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_arm,
  input  logic                   i_abort,
  input  logic [2:0]             i_src_sel,
  input  logic [7:0]             i_ina_data,
  input  logic [7:0]             i_inb_data,
  input  logic [7:0]             i_ddsa_data,
  input  logic [7:0]             i_ddsb_data,
  input  logic [15:0]            i_aud_in,
  input  logic [15:0]            i_mpx_in,
  input  logic [DECIM_WIDTH-1:0] i_decim,
  input  logic [1:0]             i_trig_mode,
  input  logic [7:0]             i_trig_level,
  input  logic [LEN_WIDTH-1:0]   i_length,
  output logic [31:0]            o_usb_wr_data,
  output logic                   o_usb_wr_valid,
  input  logic                   i_usb_wr_ready,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_overflow
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE, ST_FLUSH} state_t;
  state_t r_state, w_next_state;

  logic [7:0]             r_s;        // registered selected sample
  logic [DECIM_WIDTH-1:0] r_dec_cnt;
  logic [7:0]             r_prev;     // previous kept sample while ARMED
  logic [1:0]             r_lane;
  logic [23:0]            r_part;     // lanes 0..2 of the word being packed
  logic [LEN_WIDTH-1:0]   r_wcnt;
  logic [LEN_WIDTH-1:0]   r_len;
  logic [31:0]            r_data;
  logic                   r_valid;
  logic                   r_ovf;
`ifdef CAPTURE_HEADER_EN
  logic [23:0]            r_pre_cnt;
`endif

  logic [7:0]  w_src;
  logic        w_trig;
  logic        w_kept, w_arm_ok, w_abort, w_accept, w_room;
  logic        w_trig_ev, w_word_ev, w_last, w_offer;
  logic [31:0] w_offer_dat;
  logic        w_unused;

  // Low bytes of the 16-bit sources are never selected.
  assign w_unused = ^{i_aud_in[7:0], i_mpx_in[7:0]};

  always_comb begin
    w_src = 8'h00;
    case (i_src_sel)
      3'd0:    w_src = i_ina_data;
      3'd1:    w_src = i_inb_data;
      3'd2:    w_src = i_ddsa_data;
      3'd3:    w_src = i_ddsb_data;
      3'd4:    w_src = i_aud_in[15:8];
      3'd5:    w_src = i_mpx_in[15:8];
      default: w_src = 8'h00;
    endcase
  end

  always_comb begin
    w_trig = 1'b1;
    case (i_trig_mode)
      2'd1:    w_trig = ($signed(r_prev) < $signed(i_trig_level)) && ($signed(r_s) >= $signed(i_trig_level));
      2'd2:    w_trig = ($signed(r_prev) > $signed(i_trig_level)) && ($signed(r_s) <= $signed(i_trig_level));
      default: w_trig = 1'b1;
    endcase
  end

  assign w_kept    = (r_dec_cnt == '0);
  assign w_arm_ok  = (r_state == ST_IDLE) && i_arm && !i_abort && (i_length != '0);
  assign w_abort   = i_abort && (r_state != ST_IDLE);
  assign w_accept  = r_valid && i_usb_wr_ready;
  assign w_room    = !r_valid || i_usb_wr_ready;
  assign w_trig_ev = (r_state == ST_ARMED) && w_kept && w_trig;
  assign w_word_ev = (r_state == ST_CAPTURE) && w_kept && (r_lane == 2'd3);
  // Dropped words count too, so the last word is detected whether or not it loads.
  assign w_last    = w_word_ev && (r_wcnt == r_len - LEN_WIDTH'(1));

`ifdef CAPTURE_HEADER_EN
  assign w_offer     = w_word_ev || w_trig_ev;
  assign w_offer_dat = w_trig_ev ? {8'hA5, r_pre_cnt} : {r_s, r_part};
`else
  assign w_offer     = w_word_ev;
  assign w_offer_dat = {r_s, r_part};
`endif

  always_comb begin
    w_next_state = r_state;
    o_done       = 1'b0;
    case (r_state)
      ST_IDLE:    if (w_arm_ok) w_next_state = ST_ARMED;
      ST_ARMED:   if (w_trig_ev) w_next_state = ST_CAPTURE;
      ST_CAPTURE: if (w_last) w_next_state = ST_FLUSH;
      ST_FLUSH: begin
        if (!r_valid || i_usb_wr_ready) begin
          w_next_state = ST_IDLE;
          o_done       = 1'b1;
        end
      end
      default:    w_next_state = ST_IDLE;
    endcase
    if (w_abort) begin
      w_next_state = ST_IDLE;
      o_done       = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= ST_IDLE;
      r_s       <= '0;
      r_dec_cnt <= '0;
      r_prev    <= '0;
      r_lane    <= '0;
      r_part    <= '0;
      r_wcnt    <= '0;
      r_len     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
`ifdef CAPTURE_HEADER_EN
      r_pre_cnt <= '0;
`endif
    end else begin
      r_state <= w_next_state;
      r_s     <= w_src;

      if (w_arm_ok || (r_dec_cnt >= i_decim)) r_dec_cnt <= '0;
      else                                    r_dec_cnt <= r_dec_cnt + DECIM_WIDTH'(1);

      // Output register: abort discards any pending word.
      if (w_abort) begin
        r_valid <= 1'b0;
      end else if (w_offer && w_room) begin
        r_data  <= w_offer_dat;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end

      if (w_arm_ok)                            r_ovf <= 1'b0;
      else if (!w_abort && w_offer && !w_room) r_ovf <= 1'b1;

      if (w_arm_ok) begin
        r_prev <= i_trig_level;
        r_lane <= '0;
        r_part <= '0;
        r_wcnt <= '0;
        r_len  <= i_length;
`ifdef CAPTURE_HEADER_EN
        r_pre_cnt <= '0;
`endif
      end else if (w_abort) begin
        r_lane <= '0;
        r_part <= '0;
      end else if (w_kept && (r_state == ST_ARMED)) begin
        if (w_trig) begin
          r_part <= {16'h0000, r_s};
          r_lane <= 2'd1;
        end else begin
          r_prev <= r_s;
`ifdef CAPTURE_HEADER_EN
          if (r_pre_cnt != 24'hFFFFFF) r_pre_cnt <= r_pre_cnt + 24'd1;
`endif
        end
      end else if (w_kept && (r_state == ST_CAPTURE)) begin
        if (r_lane == 2'd3) begin
          r_lane <= 2'd0;
          r_wcnt <= r_wcnt + LEN_WIDTH'(1);
        end else begin
          case (r_lane)
            2'd0:    r_part[7:0]   <= r_s;
            2'd1:    r_part[15:8]  <= r_s;
            default: r_part[23:16] <= r_s;
          endcase
          r_lane <= r_lane + 2'd1;
        end
      end
    end
  end

  assign o_usb_wr_data  = r_data;
  assign o_usb_wr_valid = r_valid;
  assign o_overflow     = r_ovf;
  assign o_busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_capture_block.sv
`timescale 1ns/1ps
module tb_capture_block;

`ifdef CAPTURE_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif
  localparam int HOFF = HDR ? 1 : 0;

  logic        clk = 1'b0;
  logic        rst_n, arm, abort, ready;
  logic [2:0]  src_sel;
  logic [7:0]  ina, inb, ddsa, ddsb, lvl;
  logic [15:0] aud, mpx, decim;
  logic [1:0]  mode;
  logic [23:0] length;
  logic [31:0] data;
  logic        valid, busy, done, ovf;

  capture_block dut (
    .i_clk(clk), .i_reset(rst_n), .i_arm(arm), .i_abort(abort), .i_src_sel(src_sel),
    .i_ina_data(ina), .i_inb_data(inb), .i_ddsa_data(ddsa), .i_ddsb_data(ddsb),
    .i_aud_in(aud), .i_mpx_in(mpx), .i_decim(decim), .i_trig_mode(mode),
    .i_trig_level(lvl), .i_length(length), .o_usb_wr_data(data), .o_usb_wr_valid(valid),
    .i_usb_wr_ready(ready), .o_busy(busy), .o_done(done), .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [7:0]  ramp_val = 8'h00;
  logic [7:0]  step = 8'h01;
  bit          ramp_en = 1'b0;
  bit          holding = 1'b0;
  logic [31:0] held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Source k of the mux sees ramp+k on its top byte, so each select is distinguishable.
  task automatic drive_src();
    ina  = ramp_val;
    inb  = 8'(ramp_val + 8'd1);
    ddsa = 8'(ramp_val + 8'd2);
    ddsb = 8'(ramp_val + 8'd3);
    aud  = {8'(ramp_val + 8'd4), 8'h3C};
    mpx  = {8'(ramp_val + 8'd5), 8'hC3};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ramp_en) begin
      ramp_val = 8'(ramp_val + step);
      drive_src();
    end
  endtask

  // Kept sample k after arm: the ramp value presented k*(decim+1) edges after the arm edge.
  function automatic logic [7:0] model_sample(input logic [7:0] v0, input int stpi, input int d,
                                              input int sel, input int k);
    logic [7:0] r;
    r = 8'(int'(v0) + stpi * k * (d + 1));
    if (sel >= 6) return 8'h00;
    return 8'(r + 8'(sel));
  endfunction

  // Expected delivered words: optional header, then ndel packed words starting at the trigger sample.
  function automatic void build(input logic [7:0] v0, input int stpi, input int d, input int md,
                                input logic [7:0] level, input int sel, input int ndel);
    logic signed [7:0] prev, s, lv;
    int trig;
    trig = -1;
    lv   = level;
    prev = lv;
    for (int k = 0; k < 4000; k++) begin
      s = model_sample(v0, stpi, d, sel, k);
      if (md == 0 || md == 3 || (md == 1 && prev < lv && s >= lv) || (md == 2 && prev > lv && s <= lv)) begin
        trig = k;
        break;
      end
      prev = s;
    end
    if (trig < 0) return;
    if (HDR) exp_q.push_back({8'hA5, 24'(trig)});
    for (int w = 0; w < ndel; w++)
      exp_q.push_back({model_sample(v0, stpi, d, sel, trig + 4*w + 3), model_sample(v0, stpi, d, sel, trig + 4*w + 2),
                       model_sample(v0, stpi, d, sel, trig + 4*w + 1), model_sample(v0, stpi, d, sel, trig + 4*w)});
  endfunction

  function automatic logic [31:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 'x;
  endfunction

  // Compare process: every accepted word against the model, stability while stalled, done pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (holding) begin
        chk("hold_valid", {31'd0, valid}, 32'd1);
        chk("hold_data", data, held);
      end
      if (valid && ready) begin
        got_q.push_back(data);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got %h, expected no word", data);
        end else begin
          chk("word", data, exp_q.pop_front());
        end
        holding = 1'b0;
      end else if (valid) begin
        holding = 1'b1;
        held    = data;
      end else begin
        holding = 1'b0;
      end
    end else begin
      holding = 1'b0;
    end
  end

  task automatic do_arm(input logic [7:0] v0, input int stpi);
    arm      = 1'b1;
    ramp_val = v0;
    step     = 8'(stpi);
    ramp_en  = 1'b1;
    drive_src();
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic run(input string name, input logic [7:0] v0, input int stpi, input int d, input int md,
                     input logic [7:0] level, input int sel, input logic [31:0] lit);
    int d0;
    src_sel = 3'(sel);
    decim   = 16'(d);
    mode    = 2'(md);
    lvl     = level;
    length  = 24'd1;
    ready   = 1'b1;
    got_q.delete();
    exp_q.delete();
    d0 = done_cnt;
    build(v0, stpi, d, md, level, sel, 1);
    do_arm(v0, stpi);
    wait_idle({name, "_idle"}, 800);
    ramp_en = 1'b0;
    tick();
    chk({name, "_word"}, got_at(HOFF), lit);
    chk({name, "_done"}, 32'(done_cnt - d0), 32'd1);
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_ovf"}, {31'd0, ovf}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, d0;
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; ready = 1'b1;
    src_sel = 3'd0; decim = 16'd0; mode = 2'd0; lvl = 8'd0; length = 24'd2;
    drive_src();
    repeat (3) tick();
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Test 1: immediate, decim 0, two words, latency check.
    got_q.delete();
    d0 = done_cnt;
    build(8'h00, 1, 0, 0, 8'h00, 0, 2);
    do_arm(8'h00, 1);
    lat = 0;
    while (!valid && lat < 50) begin
      tick();
      lat++;
    end
    chk("t1_latency", 32'(lat), HDR ? 32'd1 : 32'd4);
    wait_idle("t1_idle", 200);
    ramp_en = 1'b0;
    tick();
    chk("t1_w0", got_at(HOFF), 32'h03020100);
    chk("t1_w1", got_at(HOFF + 1), 32'h07060504);
    chk("t1_done", 32'(done_cnt - d0), 32'd1);
    chk("t1_ovf", {31'd0, ovf}, 32'd0);
    chk("t1_pending", 32'(exp_q.size()), 32'd0);

    run("t2_decim2",   8'h00, 1, 2, 0, 8'h00, 0, 32'h09060300);
    run("t3_rising",   8'hFB, 1, 0, 1, 8'd10, 0, 32'h0D0C0B0A);
    run("t3_falling",  8'd20, -1, 0, 2, 8'd10, 0, 32'h0708090A);
    run("t_src4",      8'h00, 1, 0, 3, 8'h00, 4, 32'h07060504);
    run("t_src5_dec1", 8'h10, 1, 1, 0, 8'h00, 5, 32'h1B191715);
    run("t_src6",      8'h33, 1, 0, 0, 8'h00, 6, 32'h00000000);
    run("t_signed",    8'h70, 1, 31, 1, 8'h00, 0, 32'h70503010);
    run("t6_hdr",      8'hFD, 1, 0, 1, 8'h00, 0, 32'h03020100);
`ifdef CAPTURE_HEADER_EN
    chk("t6_header", got_at(0), 32'hA5000003);
`endif

    // Length 0 and arm+abort together are both ignored.
    length = 24'd0; arm = 1'b1; tick(); arm = 1'b0;
    chk("len0_ignored", {31'd0, busy}, 32'd0);
    length = 24'd1; arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
    chk("abort_wins", {31'd0, busy}, 32'd0);

    // Test 4: stalled sink, length 3: first offered word held, rest dropped.
    src_sel = 3'd0; decim = 16'd0; mode = 2'd0; length = 24'd3; ready = 1'b0;
    got_q.delete(); exp_q.delete();
    d0 = done_cnt;
    build(8'h00, 1, 0, 0, 8'h00, 0, HDR ? 0 : 1);
    do_arm(8'h00, 1);
    repeat (20) tick();
    chk("t4_busy", {31'd0, busy}, 32'd1);
    chk("t4_valid", {31'd0, valid}, 32'd1);
    chk("t4_data", data, HDR ? 32'hA5000000 : 32'h03020100);
    chk("t4_ovf", {31'd0, ovf}, 32'd1);
    chk("t4_no_done", 32'(done_cnt - d0), 32'd0);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("t4_arm_ignored", {31'd0, ovf}, 32'd1);
    ready = 1'b1;
    wait_idle("t4_idle", 50);
    ramp_en = 1'b0;
    tick();
    chk("t4_done", 32'(done_cnt - d0), 32'd1);
    chk("t4_pending", 32'(exp_q.size()), 32'd0);
    chk("t4_ovf_sticky", {31'd0, ovf}, 32'd1);

    // Test 5: abort mid-word, then re-arm.
    length = 24'd2;
    got_q.delete(); exp_q.delete();
    d0 = done_cnt;
    build(8'h10, 1, 0, 0, 8'h00, 0, 1);
    do_arm(8'h10, 1);
    chk("t5_arm_clears_ovf", {31'd0, ovf}, 32'd0);
    repeat (5) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_valid", {31'd0, valid}, 32'd0);
    repeat (10) tick();
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t5_pending", 32'(exp_q.size()), 32'd0);
    chk("t5_w0", got_at(HOFF), 32'h13121110);
    ramp_en = 1'b0;
    run("t5_rearm", 8'h40, 1, 0, 0, 8'h00, 0, 32'h43424140);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
